hex_display_ctrl: RTL and testbench
===================================

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, stable cycles required to accept a button press or release (minimum 2).
REQ-002 Parameter BLINK_CYCLES, default 12500000, cycles per blink half-period while frozen (minimum 2).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 data_in  input  16  value to display; nibble 3 is the most significant.
REQ-007 data_valid  input  1  data_in is offered this cycle.
REQ-008 data_ready  output  1  block accepts data_in this cycle.
REQ-009 btn_n  input  1  raw, asynchronous pushbutton; low = pressed.
REQ-010 lz_en  input  1  leading-zero blanking enable, sampled each cycle.
REQ-011 digit3..digit0  output  4 each  nibbles fed to the four downstream hex_decoder instances.
REQ-012 blank  output  4  bit i high = digit i dark; the integrating top forces those segments to 7'h7F (all off).
REQ-013 frozen  output  1  display is held and ignoring new data.
REQ-014 update  output  1  one-cycle pulse when a new value has been loaded.

Function
REQ-015 btn_n SHALL pass through a 2-flop synchronizer before any use; the synchronizer flops SHALL reset to 1.
REQ-016 Debounce FSM states SHALL be IDLE, PRESS_WAIT, HELD, REL_WAIT, with one counter cleared on every state change.
REQ-017 IDLE->PRESS_WAIT when the synced button is pressed.
REQ-018 PRESS_WAIT: released -> IDLE; pressed with counter at DEBOUNCE_CYCLES-1 -> HELD and toggle frozen on that edge; otherwise increment.
REQ-019 HELD->REL_WAIT when the synced button is released.
REQ-020 REL_WAIT: pressed -> HELD without toggling; released with counter at DEBOUNCE_CYCLES-1 -> IDLE; otherwise increment.
REQ-021 Exactly one frozen toggle SHALL occur per accepted press; holding the button SHALL never retoggle.
REQ-022 data_ready SHALL equal ~frozen, driven from a register (no combinational path from data_valid).
REQ-023 A transfer is data_valid && data_ready at a rising edge; the display register SHALL load data_in on that edge, and digit3..0 SHALL show it from the next cycle (1-cycle latency).
REQ-024 update SHALL be high for exactly the cycle after each transfer; back-to-back transfers SHALL give back-to-back update pulses.
REQ-025 Transfer and press-confirm on the same edge: the transfer SHALL complete; frozen takes effect from the next cycle.
REQ-026 While frozen, the display register SHALL hold; leaving freeze SHALL keep the held value until the next transfer.
REQ-027 Leading-zero blanking, lz_en=1: digit i (i=3..1) SHALL be blanked when it and every higher nibble are 0; digit0 SHALL never be blanked by this rule. lz_en=0: no leading-zero blanking.
REQ-028 Blink: on entering freeze, the blink counter and phase SHALL clear to 0; while frozen, phase SHALL toggle when the counter reaches BLINK_CYCLES-1, and the counter SHALL wrap to 0.
REQ-029 When phase=1, blank SHALL be 4'b1111; when phase=0, blank SHALL follow REQ-027.
REQ-030 When not frozen, phase SHALL be held at 0 and the counter at 0.
REQ-031 blank SHALL be registered and SHALL change on the same edge as the digits it qualifies.

Reset
REQ-032 While rst_n=0: FSM=IDLE; counters=0; display register=16'h0000; digit3..0=0; frozen=0; data_ready=0; update=0; phase=0; blank=4'b0000.
REQ-033 data_ready SHALL first go high on the first clock edge after rst_n deasserts.
REQ-034 Reset asserted mid-debounce or mid-blink SHALL abort the operation immediately, with no pending toggle after release.

Verification (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8)
REQ-035 Reset release, then data_in=16'h00A5 with valid for 1 cycle and lz_en=1 -> next cycle digits 0,0,A,5; blank=4'b1100; update pulses once.
REQ-036 btn_n low for 3 synced cycles, then high -> no toggle; btn_n low for 10 cycles -> frozen=1 exactly once and data_ready=0 the cycle after the toggle.
REQ-037 While frozen, offer 16'h1234 with valid -> digits unchanged, no update; blank alternates 4'b1111 / lz pattern every 8 cycles, starting visible.
REQ-038 Press-confirm and transfer of 16'h0000 on the same edge -> value loaded, update=1, frozen=1 next cycle; lz_en=1 gives blank=4'b1110 during visible phases.
REQ-039 Assert rst_n=0 during PRESS_WAIT and during blink -> all outputs return to REQ-032 values asynchronously; no toggle occurs after release.

Source files
------------

// File: rtl/hex_display_ctrl_if.sv
// Data handshake and display-side signals of the four-digit hex display
// controller. The producer/monitor side uses master; the controller uses slave.
interface hex_display_ctrl_if;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [3:0]  digit3;
    logic [3:0]  digit2;
    logic [3:0]  digit1;
    logic [3:0]  digit0;
    logic [3:0]  blank;
    logic        frozen;
    logic        update;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  digit3,
        input  digit2,
        input  digit1,
        input  digit0,
        input  blank,
        input  frozen,
        input  update
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output digit3,
        output digit2,
        output digit1,
        output digit0,
        output blank,
        output frozen,
        output update
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Four-digit hex display controller: ready/valid value capture, debounced
// freeze pushbutton, leading-zero blanking and blink while frozen.
module hex_display_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_n,
    input  logic              lz_en,
    hex_display_ctrl_if.slave bus
);
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    logic          r_btn_meta;
    logic          r_btn_sync;
    state_t        r_state;
    logic [DW-1:0] r_cnt;
    logic          r_frozen;
    logic          r_ready;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic [15:0]   r_disp;
    logic [3:0]    r_blank;
    logic          r_update;

    logic          w_pressed;
    logic          w_cnt_done;
    logic          w_toggle;
    logic          w_frozen_next;
    logic          w_xfer;
    logic [15:0]   w_disp_next;
    logic [3:0]    w_lz_blank;
    logic [BW-1:0] w_blink_cnt_next;
    logic          w_phase_next;

    assign w_pressed     = ~r_btn_sync;
    assign w_cnt_done    = (r_cnt == DW'(DEBOUNCE_CYCLES - 1));
    // The only freeze toggle: the edge on which a press is confirmed.
    assign w_toggle      = (r_state == PRESS_WAIT) && w_pressed && w_cnt_done;
    assign w_frozen_next = r_frozen ^ w_toggle;
    // Ready is a register, so a transfer never depends combinationally on valid.
    assign w_xfer        = bus.data_valid && r_ready;
    assign w_disp_next   = w_xfer ? bus.data_in : r_disp;

    // Leading-zero blanking on the value that will be displayed next cycle;
    // digit0 is never blanked by this rule.
    assign w_lz_blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz
            assign w_lz_blank[gi] = lz_en && (w_disp_next[15:4*gi] == '0);
        end
    endgenerate

    // Blink counter: cleared on any freeze toggle and while not frozen.
    always_comb begin
        w_blink_cnt_next = '0;
        w_phase_next     = 1'b0;
        if (!w_toggle && r_frozen) begin
            if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                w_blink_cnt_next = '0;
                w_phase_next     = ~r_phase;
            end else begin
                w_blink_cnt_next = r_blink_cnt + 1'b1;
                w_phase_next     = r_phase;
            end
        end
    end

    // Two-flop synchronizer for the raw pushbutton, idling released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta <= 1'b1;
            r_btn_sync <= 1'b1;
        end else begin
            r_btn_meta <= btn_n;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Debounce FSM with frozen flag and ready as registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_frozen <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_frozen <= w_frozen_next;
            r_ready  <= ~w_frozen_next;
            case (r_state)
                IDLE: begin
                    if (w_pressed) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_pressed) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_pressed) begin
                        r_state <= REL_WAIT;
                        r_cnt   <= '0;
                    end
                end
                REL_WAIT: begin
                    if (w_pressed) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_next;
            r_phase     <= w_phase_next;
        end
    end

    // Display value, its blanking mask and the update pulse move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp   <= 16'h0000;
            r_blank  <= 4'b0000;
            r_update <= 1'b0;
        end else begin
            r_disp   <= w_disp_next;
            r_blank  <= w_phase_next ? 4'b1111 : w_lz_blank;
            r_update <= w_xfer;
        end
    end

    assign bus.data_ready = r_ready;
    assign bus.frozen     = r_frozen;
    assign bus.update     = r_update;
    assign bus.blank      = r_blank;
    assign bus.digit3     = r_disp[15:12];
    assign bus.digit2     = r_disp[11:8];
    assign bus.digit1     = r_disp[7:4];
    assign bus.digit0     = r_disp[3:0];
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a run-length / elapsed-time behavioural model.
module tb_hex_display_ctrl;
    localparam int D = 4;
    localparam int B = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_n;
    logic lz_en;

    hex_display_ctrl_if bus ();

    hex_display_ctrl #(.DEBOUNCE_CYCLES(D), .BLINK_CYCLES(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
        .lz_en (lz_en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Leading zero nibbles above digit0 are dark when enabled.
    function automatic logic [3:0] lzb(input logic [15:0] v, input logic en);
        logic [3:0] b;
        b = 4'b0000;
        for (int i = 1; i < 4; i++)
            if (en && ((v >> (4 * i)) == 16'd0)) b[i] = 1'b1;
        return b;
    endfunction

    // Behavioural model: a press counts after D+1 consecutive synced-low
    // cycles while armed; re-arming needs D+1 consecutive synced-high cycles.
    // Blink phase follows the number of cycles spent frozen.
    logic        m_s1, m_s2, m_armed, m_frozen, m_ready, m_update;
    int          m_run, m_age;
    logic [15:0] m_disp;
    logic [3:0]  m_blank;

    always @(posedge clk or negedge rst_n) begin
        logic xfer, toggled, phase;
        if (!rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_armed = 1'b1; m_run = 0;
            m_frozen = 1'b0; m_ready = 1'b0; m_update = 1'b0;
            m_disp = 16'h0000; m_age = 0; m_blank = 4'b0000;
        end else begin
            xfer = bus.data_valid && m_ready;
            m_update = xfer;
            if (xfer) m_disp = bus.data_in;
            toggled = 1'b0;
            if (m_armed) begin
                if (!m_s2) begin
                    m_run++;
                    if (m_run == D + 1) begin toggled = 1'b1; m_armed = 1'b0; m_run = 0; end
                end else m_run = 0;
            end else begin
                if (m_s2) begin
                    m_run++;
                    if (m_run == D + 1) begin m_armed = 1'b1; m_run = 0; end
                end else m_run = 0;
            end
            if (toggled) begin m_frozen = !m_frozen; m_age = 0; end
            else if (m_frozen) m_age++;
            m_ready = !m_frozen;
            phase = m_frozen && (((m_age / B) % 2) == 1);
            m_blank = phase ? 4'b1111 : lzb(m_disp, lz_en);
            m_s2 = m_s1;
            m_s1 = btn_n;
        end
    end

    // Per-cycle compare against the model, away from the rising edge.
    int frz_rises = 0;
    int upd_seen = 0;
    logic prev_frozen = 1'b0;
    always @(negedge clk) begin
        chk("digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, m_disp);
        chk("blank", bus.blank, m_blank);
        chk("frozen", bus.frozen, m_frozen);
        chk("ready", bus.data_ready, m_ready);
        chk("update", bus.update, m_update);
        if (bus.frozen && !prev_frozen) frz_rises++;
        if (bus.update) upd_seen++;
        prev_frozen = bus.frozen;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_digits"}, {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h0000);
        chk({tag, "_blank"}, bus.blank, 4'b0000);
        chk({tag, "_frozen"}, bus.frozen, 1'b0);
        chk({tag, "_ready"}, bus.data_ready, 1'b0);
        chk({tag, "_update"}, bus.update, 1'b0);
    endtask

    task automatic press_release();
        btn_n = 1'b0; cyc(10);
        btn_n = 1'b1; cyc(10);
    endtask

    initial begin
        int fcount, ucount, rises0, btn_left, lz_left, k;
        bit got;
        rst_n = 1'b0; btn_n = 1'b1; lz_en = 1'b0;
        bus.data_in = 16'h0000; bus.data_valid = 1'b0;
        cyc(3);
        chk_reset_vals("por");
        #2 rst_n = 1'b1;
        cyc(1);
        chk("ready_after_release", bus.data_ready, 1'b1);

        // First value with leading-zero blanking.
        bus.data_in = 16'h00A5; bus.data_valid = 1'b1; lz_en = 1'b1;
        cyc(1);
        bus.data_valid = 1'b0;
        chk("a5_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h00A5);
        chk("a5_blank", bus.blank, 4'b1100);
        chk("a5_update", bus.update, 1'b1);
        cyc(1);
        chk("a5_update_drop", bus.update, 1'b0);

        // Short press is rejected, long press freezes exactly once.
        btn_n = 1'b0; cyc(3);
        btn_n = 1'b1; cyc(10);
        chk("short_press_frozen", bus.frozen, 1'b0);
        btn_n = 1'b0; cyc(10);
        chk("long_press_frozen", bus.frozen, 1'b1);
        chk("long_press_ready", bus.data_ready, 1'b0);
        chk("long_press_rises", frz_rises, 1);
        btn_n = 1'b1; cyc(10);
        chk("hold_no_retoggle", frz_rises, 1);

        // Frozen: data ignored, blink period of 2*B cycles.
        rises0 = upd_seen;
        bus.data_in = 16'h1234; bus.data_valid = 1'b1;
        fcount = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            if (bus.blank == 4'b1111) fcount++;
        end
        bus.data_valid = 1'b0;
        chk("frozen_hold_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h00A5);
        chk("frozen_no_update", upd_seen - rises0, 0);
        chk("blink_dark_cycles", fcount, 16);

        // Unfreeze keeps the held value.
        press_release();
        chk("unfrozen", bus.frozen, 1'b0);
        chk("unfrozen_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h00A5);

        // Transfer of zero on the press-confirm edge.
        bus.data_in = 16'h5555; bus.data_valid = 1'b1; cyc(1);
        bus.data_in = 16'h0000; btn_n = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc(1);
            if (bus.frozen) begin
                got = 1'b1;
                chk("same_edge_update", bus.update, 1'b1);
                chk("same_edge_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h0000);
                chk("same_edge_blank", bus.blank, 4'b1110);
            end
        end
        chk("same_edge_freeze_seen", got, 1'b1);
        bus.data_valid = 1'b0; btn_n = 1'b1; cyc(10);
        press_release();

        // Reset during PRESS_WAIT aborts the pending toggle.
        rises0 = frz_rises;
        btn_n = 1'b0; cyc(3);
        #2 rst_n = 1'b0; btn_n = 1'b1;
        #1 chk_reset_vals("rst_press");
        cyc(3);
        #2 rst_n = 1'b1;
        cyc(10);
        chk("rst_press_no_toggle", frz_rises - rises0, 0);
        chk("rst_press_ready", bus.data_ready, 1'b1);

        // Reset during blink.
        bus.data_in = 16'h0F00; bus.data_valid = 1'b1; cyc(1); bus.data_valid = 1'b0;
        btn_n = 1'b0; cyc(10); btn_n = 1'b1; cyc(12);
        chk("pre_blink_rst_frozen", bus.frozen, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_blink");
        cyc(3);
        #2 rst_n = 1'b1;
        cyc(10);
        chk("rst_blink_frozen", bus.frozen, 1'b0);

        // Randomized traffic with run-length button behaviour.
        btn_left = 0; lz_left = 0;
        for (int i = 0; i < 4000; i++) begin
            cyc(1);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                cyc(1);
                #2 rst_n = 1'b1;
            end
            if (btn_left == 0) begin
                btn_n = ~btn_n;
                btn_left = $urandom_range(1, 12);
            end
            btn_left--;
            if (lz_left == 0) begin
                lz_en = $urandom_range(0, 1);
                lz_left = $urandom_range(1, 20);
            end
            lz_left--;
            k = $urandom_range(0, 4);
            bus.data_in = (k == 4) ? 16'h0000 : 16'($urandom_range(0, 65535) >> (4 * k));
            bus.data_valid = $urandom_range(0, 1);
        end
        bus.data_valid = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
